// File: rtl/mb_sata_bridge_pkg.sv
// mb_sata_bridge_pkg: shared FSM state type and constants for the MicroBlaze-to-SATA register bridge
package mb_sata_bridge_pkg;
  typedef enum logic [2:0] {
    IDLE,
    HOLD_CHK,
    RD_WAIT,
    ACK,
    ERR_ACK,
    DONE
  } state_t;
  localparam int unsigned CTRL_ADDR_W = 5;
  localparam logic [3:0]  MB_FULL_BE  = 4'hF;
  localparam logic [31:0] ERR_RD_DATA = 32'h0;
endpackage

// File: rtl/mb_sata_bridge_timer.sv
// mb_sata_bridge_timer: loadable down-counter whose flag marks the last cycle of a hold-wait window
module mb_sata_bridge_timer #(
  parameter int unsigned LOAD_VAL = 1024
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);
  localparam int unsigned W = $clog2(LOAD_VAL + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d  = load_i ? W'(LOAD_VAL) : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  assign done_o = cnt_q == W'(1);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
endmodule

// File: rtl/mb_sata_bridge.sv
// mb_sata_bridge: serialises MB register accesses onto per-channel SATA host register ports.
// Define MB_SATA_BRIDGE_TIMEOUT_EN to abort hold waits longer than TIMEOUT_CYCLES with an error ack.
module mb_sata_bridge
  import mb_sata_bridge_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned ADDR_LSB       = 2,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [31:0]            MB_ADDR,
  input  logic                   MB_CS,
  input  logic                   MB_RNW,
  input  logic [31:0]            MB_DATA_IN,
  input  logic [3:0]             MB_BE,
  output logic [31:0]            MB_DATA_OUT,
  output logic                   MB_RD_ACK,
  output logic                   MB_WR_ACK,
  output logic                   MB_ERROR,
  output logic [NUM_CH-1:0]      CTRL_READ_EN,
  output logic [NUM_CH-1:0]      CTRL_WRITE_EN,
  output logic [CTRL_ADDR_W-1:0] CTRL_ADDR_REG,
  output logic [31:0]            CTRL_DATA_OUT,
  input  logic [NUM_CH*32-1:0]   CTRL_DATA_IN,
  input  logic [NUM_CH-1:0]      SATA_WR_HOLD_IN,
  input  logic [NUM_CH-1:0]      SATA_RD_HOLD_IN
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  state_t                 state_q, state_d;
  logic                   rnw_q, rnw_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [3:0]             lat_q, lat_d;
  logic [CTRL_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [CH_W-1:0]        mb_ch;
  logic                   bad_access;
  logic                   hold;
  logic                   fire;
  logic                   ack;
  logic                   tmo_expired;
  logic [NUM_CH-1:0]      strobe;
  logic                   unused_addr;
  assign unused_addr = ^MB_ADDR;
  assign mb_ch       = MB_ADDR[ADDR_LSB+5 +: CH_W];
  assign bad_access  = 32'(mb_ch) >= NUM_CH || (!MB_RNW && MB_BE != MB_FULL_BE);
  assign hold        = rnw_q ? SATA_RD_HOLD_IN[ch_q] : SATA_WR_HOLD_IN[ch_q];
  // Strobe is combinational on the hold bit so it lands in the first HOLD_CHK cycle the bit reads 0.
  assign fire          = state_q == HOLD_CHK && !hold;
  assign strobe        = fire ? NUM_CH'(1) << ch_q : '0;
  assign CTRL_READ_EN  = rnw_q ? strobe : '0;
  assign CTRL_WRITE_EN = rnw_q ? '0 : strobe;
  assign ack           = state_q == ACK || state_q == ERR_ACK;
  assign MB_RD_ACK     = ack && rnw_q;
  assign MB_WR_ACK     = ack && !rnw_q;
  assign MB_ERROR      = state_q == ERR_ACK;
  assign MB_DATA_OUT   = rdata_q;
  assign CTRL_ADDR_REG = addr_q;
  assign CTRL_DATA_OUT = wdata_q;
`ifdef MB_SATA_BRIDGE_TIMEOUT_EN
  mb_sata_bridge_timer #(
    .LOAD_VAL(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i  (CLK),
    .rst_n_i(RESET_N),
    .load_i (state_q == IDLE),
    .en_i   (state_q == HOLD_CHK),
    .done_o (tmo_expired)
  );
`else
  logic unused_tmo;
  assign unused_tmo  = TIMEOUT_CYCLES != 0;
  assign tmo_expired = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    rnw_d   = rnw_q;
    ch_d    = ch_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE:
        if (MB_CS) begin
          rnw_d = MB_RNW;
          ch_d  = mb_ch;
          if (bad_access) begin
            state_d = ERR_ACK;
            rdata_d = MB_RNW ? ERR_RD_DATA : rdata_q;
          end else begin
            state_d = HOLD_CHK;
            addr_d  = MB_ADDR[ADDR_LSB +: CTRL_ADDR_W];
            wdata_d = MB_DATA_IN;
          end
        end
      HOLD_CHK:
        if (!hold) begin
          state_d = rnw_q ? RD_WAIT : ACK;
          lat_d   = 4'(READ_LATENCY);
        end else if (tmo_expired) begin
          state_d = ERR_ACK;
          rdata_d = rnw_q ? ERR_RD_DATA : rdata_q;
        end
      RD_WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          state_d = ACK;
          rdata_d = CTRL_DATA_IN[32*ch_q +: 32];
        end
      end
      ACK, ERR_ACK: state_d = DONE;
      DONE:         state_d = MB_CS ? DONE : IDLE;
      default:      state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= IDLE;
      rnw_q   <= 1'b0;
      ch_q    <= '0;
      lat_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rnw_q   <= rnw_d;
      ch_q    <= ch_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
endmodule

// File: tb/tb_mb_sata_bridge.sv
// tb_mb_sata_bridge: directed self-checking bench for mb_sata_bridge (3 channels, read latency 2, timeout 16)
module tb_mb_sata_bridge;
  localparam int NCH = 3;
  localparam int RL  = 2;
  localparam int TMO = 16;
  logic           clk;
  logic           rst_n;
  logic [31:0]    mb_addr;
  logic           mb_cs;
  logic           mb_rnw;
  logic [31:0]    mb_data_in;
  logic [3:0]     mb_be;
  logic [31:0]    mb_data_out;
  logic           mb_rd_ack;
  logic           mb_wr_ack;
  logic           mb_error;
  logic [NCH-1:0] ctrl_read_en;
  logic [NCH-1:0] ctrl_write_en;
  logic [4:0]     ctrl_addr_reg;
  logic [31:0]    ctrl_data_out;
  logic [NCH*32-1:0] ctrl_data_in;
  logic [NCH-1:0] wr_hold;
  logic [NCH-1:0] rd_hold;
  int n_checks;
  int n_errors;
  mb_sata_bridge #(
    .NUM_CH(NCH),
    .ADDR_LSB(2),
    .READ_LATENCY(RL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .MB_ADDR(mb_addr),
    .MB_CS(mb_cs),
    .MB_RNW(mb_rnw),
    .MB_DATA_IN(mb_data_in),
    .MB_BE(mb_be),
    .MB_DATA_OUT(mb_data_out),
    .MB_RD_ACK(mb_rd_ack),
    .MB_WR_ACK(mb_wr_ack),
    .MB_ERROR(mb_error),
    .CTRL_READ_EN(ctrl_read_en),
    .CTRL_WRITE_EN(ctrl_write_en),
    .CTRL_ADDR_REG(ctrl_addr_reg),
    .CTRL_DATA_OUT(ctrl_data_out),
    .CTRL_DATA_IN(ctrl_data_in),
    .SATA_WR_HOLD_IN(wr_hold),
    .SATA_RD_HOLD_IN(rd_hold)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mk_addr(input int ch, input int rg);
    return 32'((ch << 7) | (rg << 2));
  endfunction
  task automatic start(input logic rnw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #1;
    mb_rnw = rnw; mb_addr = a; mb_data_in = d; mb_be = be; mb_cs = 1'b1;
  endtask
  task automatic drop_cs();
    @(posedge clk); #1;
    mb_cs = 1'b0;
  endtask
  task automatic held_quiet(input string tag);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check({tag, "/held_cs"}, 32'({ctrl_read_en, ctrl_write_en, mb_rd_ack, mb_wr_ack, mb_error}), 32'h0);
    end
  endtask
  task automatic do_write(input string tag, input int ch, input int rg, input logic [31:0] d);
    start(1'b0, mk_addr(ch, rg), d, 4'hF);
    @(negedge clk);
    check({tag, "/wr_en_n"}, 32'(ctrl_write_en), 32'h0);
    @(negedge clk);
    check({tag, "/wr_en_n1"}, 32'(ctrl_write_en), 32'(1 << ch));
    check({tag, "/addr_reg"}, 32'(ctrl_addr_reg), 32'(rg));
    check({tag, "/data_out"}, ctrl_data_out, d);
    check({tag, "/ack_n1"}, 32'({mb_rd_ack, mb_wr_ack, mb_error}), 32'h0);
    @(negedge clk);
    check({tag, "/ack_n2"}, 32'({mb_rd_ack, mb_wr_ack, mb_error}), 32'b010);
    check({tag, "/wr_en_n2"}, 32'(ctrl_write_en), 32'h0);
    held_quiet(tag);
    drop_cs();
  endtask
  task automatic do_read(input string tag, input int ch, input int rg, input logic [31:0] exp);
    start(1'b1, mk_addr(ch, rg), 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check({tag, "/rd_en_n1"}, 32'(ctrl_read_en), 32'(1 << ch));
    check({tag, "/wr_en_n1"}, 32'(ctrl_write_en), 32'h0);
    check({tag, "/addr_reg"}, 32'(ctrl_addr_reg), 32'(rg));
    repeat (RL) @(negedge clk);
    check({tag, "/early_ack"}, 32'({mb_rd_ack, mb_wr_ack, ctrl_read_en}), 32'h0);
    @(negedge clk);
    check({tag, "/ack"}, 32'({mb_rd_ack, mb_wr_ack, mb_error}), 32'b100);
    check({tag, "/data"}, mb_data_out, exp);
    held_quiet(tag);
    check({tag, "/data_hold"}, mb_data_out, exp);
    drop_cs();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int strobes;
    int strobe_cyc;
    int ack_cyc;
    int err_seen;
    logic [31:0] dat_seen;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; mb_cs = 1'b0; mb_rnw = 1'b0; mb_addr = '0; mb_data_in = '0; mb_be = '0;
    wr_hold = '0; rd_hold = '0;
    ctrl_data_in = {32'h0BAD_F00D, 32'hDEAD_BEEF, 32'h1234_5678};
    repeat (2) @(negedge clk);
    check("reset/ctl", 32'({ctrl_read_en, ctrl_write_en, mb_rd_ack, mb_wr_ack, mb_error}), 32'h0);
    check("reset/data", mb_data_out, 32'h0);
    check("reset/ctrl_regs", 32'(ctrl_addr_reg) | ctrl_data_out, 32'h0);
    rst_n = 1'b1;
    do_write("wr_ch1", 1, 3, 32'hA5A5_0001);
    do_read("rd_ch0", 0, 0, 32'h1234_5678);
    do_read("rd_ch2", 2, 9, 32'h0BAD_F00D);
    do_write("wr_ch2_r31", 2, 31, 32'hFFFF_0000);
    // write held off for 10 cycles on ch0
    wr_hold[0] = 1'b1;
    start(1'b0, mk_addr(0, 4), 32'h5555_AAAA, 4'hF);
    @(negedge clk);
    strobes = 0; strobe_cyc = -1; ack_cyc = -1;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      if (i == 11) wr_hold[0] = 1'b0;
      @(negedge clk);
      if (ctrl_write_en != 0) begin
        strobes++;
        strobe_cyc = i;
        check("wr_hold/strobe_val", 32'(ctrl_write_en), 32'b001);
      end
      if (mb_wr_ack && ack_cyc < 0) ack_cyc = i;
    end
    check("wr_hold/strobes", 32'(strobes), 32'd1);
    check("wr_hold/strobe_cyc", 32'(strobe_cyc), 32'd11);
    check("wr_hold/ack_cyc", 32'(ack_cyc), 32'd12);
    drop_cs();
    // bad byte enables: error ack at n+1, CTRL registers keep the last accepted access
    start(1'b0, mk_addr(0, 7), 32'h1111_1111, 4'h3);
    @(negedge clk);
    @(negedge clk);
    check("bad_be/ack", 32'({mb_rd_ack, mb_wr_ack, mb_error}), 32'b011);
    check("bad_be/strobes", 32'({ctrl_read_en, ctrl_write_en}), 32'h0);
    check("bad_be/addr_reg", 32'(ctrl_addr_reg), 32'd4);
    check("bad_be/data_out", ctrl_data_out, 32'h5555_AAAA);
    @(negedge clk);
    check("bad_be/ack_gone", 32'({mb_rd_ack, mb_wr_ack, mb_error}), 32'h0);
    drop_cs();
    start(1'b1, mk_addr(3, 4), 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check("bad_ch/ack", 32'({mb_rd_ack, mb_wr_ack, mb_error}), 32'b101);
    check("bad_ch/data", mb_data_out, 32'h0);
    check("bad_ch/strobes", 32'({ctrl_read_en, ctrl_write_en}), 32'h0);
    drop_cs();
    // read hold stuck on ch1
    rd_hold[1] = 1'b1;
    start(1'b1, mk_addr(1, 2), 32'h0, 4'hF);
    @(negedge clk);
    strobes = 0; ack_cyc = -1; err_seen = 0; dat_seen = '1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (ctrl_read_en != 0) strobes++;
      if (mb_rd_ack && ack_cyc < 0) begin
        ack_cyc = i; err_seen = int'(mb_error); dat_seen = mb_data_out;
      end
    end
    check("rd_hold/strobes", 32'(strobes), 32'd0);
`ifdef MB_SATA_BRIDGE_TIMEOUT_EN
    check("tmo/ack_cyc", 32'(ack_cyc), 32'(TMO + 1));
    check("tmo/error", 32'(err_seen), 32'd1);
    check("tmo/data", dat_seen, 32'h0);
    drop_cs();
    rd_hold[1] = 1'b0;
`else
    check("no_tmo/ack", 32'(ack_cyc), 32'hFFFF_FFFF);
    @(posedge clk); #1;
    rd_hold[1] = 1'b0;
    ack_cyc = -1;
    for (int i = 0; i < 10 && ack_cyc < 0; i++) begin
      @(negedge clk);
      if (ctrl_read_en != 0) strobes++;
      if (mb_rd_ack) begin
        ack_cyc = i; err_seen = int'(mb_error); dat_seen = mb_data_out;
      end
    end
    check("no_tmo/release_ack", 32'(ack_cyc), 32'd3);
    check("no_tmo/release_strobes", 32'(strobes), 32'd1);
    check("no_tmo/release_data", dat_seen, 32'hDEAD_BEEF);
    check("no_tmo/release_err", 32'(err_seen), 32'd0);
    drop_cs();
`endif
    // reset asserted during RD_WAIT
    start(1'b1, mk_addr(0, 5), 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid/ctl", 32'({ctrl_read_en, ctrl_write_en, mb_rd_ack, mb_wr_ack, mb_error}), 32'h0);
    check("rst_mid/data", mb_data_out, 32'h0);
    check("rst_mid/addr_reg", 32'(ctrl_addr_reg), 32'h0);
    mb_cs = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if ({ctrl_read_en, ctrl_write_en, mb_rd_ack, mb_wr_ack, mb_error} != 0) strobes++;
    end
    check("rst_mid/quiet", 32'(strobes), 32'd0);
    do_read("post_rst", 2, 1, 32'h0BAD_F00D);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
